// File: rtl/gray_sync_decoder.sv
// Synchronizes an asynchronous Gray count, decodes it to binary and polices single-step transitions.
// Optional macro GRAY_DEC_DIR_EN accepts legal down steps and adds the dir output.
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] g_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] b_out,
  output logic             upd,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] step_cnt,
`ifdef GRAY_DEC_DIR_EN
  output logic             dir,
`endif
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int WAIT_W = $clog2(SYNC_STAGES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  g_prev_q, g_prev_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              upd_q, upd_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef GRAY_DEC_DIR_EN
  logic              dir_q, dir_d;
  logic              down_step;
`endif

  logic [WIDTH-1:0]  g_s;
  logic [WIDTH-1:0]  b_new;
  logic [WIDTH-1:0]  diff;
  logic [WIDTH-1:0]  delta;
  logic              changed;
  logic              one_hot;
  logic              up_step;

  // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= g_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    b_new = '0;
    for (int i = 0; i < WIDTH; i++) b_new[i] = ^(g_s >> i);
  end

  assign diff    = g_s ^ g_prev_q;
  assign changed = |diff;
  assign one_hot = changed && ((diff & (diff - WIDTH'(1))) == '0);
  assign delta   = b_new - b_q;
  assign up_step = one_hot && (delta == WIDTH'(1));
`ifdef GRAY_DEC_DIR_EN
  assign down_step = one_hot && (delta == '1);
`endif

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    g_prev_d = g_prev_q;
    b_d      = b_q;
    upd_d    = 1'b0;
    locked_d = locked_q;
    err_d    = err_clr ? 1'b0 : err_q;
    cnt_d    = cnt_q;
`ifdef GRAY_DEC_DIR_EN
    dir_d    = dir_q;
`endif
    unique case (state_q)
      ST_INIT: begin
        if (wait_q == WAIT_W'(SYNC_STAGES - 1)) state_d = ST_LOAD;
        else wait_d = wait_q + WAIT_W'(1);
      end
      ST_LOAD: begin
        b_d      = b_new;
        g_prev_d = g_s;
        locked_d = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        g_prev_d = g_s;
        if (changed) begin
          b_d   = b_new;
          upd_d = 1'b1;
          if (up_step) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
`ifdef GRAY_DEC_DIR_EN
            dir_d = 1'b1;
          end else if (down_step) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            dir_d = 1'b0;
`endif
          end else begin
            // A new violation overrides a coincident err_clr.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      wait_q   <= '0;
      g_prev_q <= '0;
      b_q      <= '0;
      upd_q    <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef GRAY_DEC_DIR_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      g_prev_q <= g_prev_d;
      b_q      <= b_d;
      upd_q    <= upd_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`ifdef GRAY_DEC_DIR_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign b_out     = b_q;
  assign upd       = upd_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign step_cnt  = cnt_q;
  assign dbg_state = state_q;
`ifdef GRAY_DEC_DIR_EN
  assign dir       = dir_q;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder: scoreboarded update pulses plus latency, reset and sticky-error checks.
module tb_gray_sync_decoder;

  localparam int W     = 4;
  localparam int CW    = 4;
  localparam int EXP_W = 2 + CW + W;
`ifdef GRAY_DEC_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [W-1:0]  g_in;
  logic          err_clr;
  logic [W-1:0]  b_out;
  logic          upd;
  logic          locked;
  logic          err;
  logic [CW-1:0] step_cnt;
  logic [1:0]    dbg_state;
  logic          dir_obs;

  int vectors;
  int miscompares;
  logic [EXP_W-1:0] exp_q[$];
  logic [CW-1:0]    cnt_m;

  gray_sync_decoder #(.WIDTH(W), .SYNC_STAGES(2), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .g_in      (g_in),
    .err_clr   (err_clr),
    .b_out     (b_out),
    .upd       (upd),
    .locked    (locked),
    .err       (err),
    .step_cnt  (step_cnt),
`ifdef GRAY_DEC_DIR_EN
    .dir       (dir_obs),
`endif
    .dbg_state (dbg_state)
  );

`ifndef GRAY_DEC_DIR_EN
  assign dir_obs = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] enc(input int i);
    logic [W-1:0] v;
    v = W'(i);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + CW'(1);
  endfunction

  // scoreboard: every update pulse consumes one expected {dir, err, cnt, b}
  always @(negedge clk) begin
    if (rst === 1'b0 && upd === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_upd", 16'(upd), 16'(0));
      else check("upd_result", 16'({dir_obs, err, step_cnt, b_out}), 16'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic step(input logic [W-1:0] g, input logic [W-1:0] eb, input logic eerr,
                      input logic [CW-1:0] ecnt, input logic edir, input bit clr_det);
    @(negedge clk);
    g_in = g;
    exp_q.push_back({DIR_EN & edir, eerr, ecnt, eb});
    @(negedge clk);
    check("upd_early1", 16'(upd), 16'(0));
    @(negedge clk);
    check("upd_early2", 16'(upd), 16'(0));
    if (clr_det) err_clr = 1'b1;
    @(negedge clk);
    check("upd_pulse", 16'(upd), 16'(1));
    err_clr = 1'b0;
    @(negedge clk);
    check("upd_single", 16'(upd), 16'(0));
    check("sb_drained", 16'(exp_q.size()), 16'(0));
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 16'(err), 16'(0));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    g_in    = '0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", 16'({locked, upd, err, step_cnt, b_out, dir_obs}), 16'(0));
    check("rst_state", 16'(dbg_state), 16'(0));
    rst = 1'b0;

    // lock after INIT + LOAD
    @(negedge clk);
    check("lock_e1", 16'(locked), 16'(0));
    @(negedge clk);
    check("lock_e2", 16'(locked), 16'(0));
    @(negedge clk);
    check("lock_e3", 16'(locked), 16'(1));
    check("load_b", 16'(b_out), 16'(0));
    check("load_upd", 16'(upd), 16'(0));
    check("run_state", 16'(dbg_state), 16'(2));

    // legal up steps
    step(4'b0001, 4'd1, 1'b0, 4'd1, 1'b1, 1'b0);
    step(4'b0011, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0);
    step(4'b0010, 4'd3, 1'b0, 4'd3, 1'b1, 1'b0);
    cnt_m = 4'd3;

    // down steps
    if (DIR_EN) begin
      step(4'b0011, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0);
      step(4'b0001, 4'd1, 1'b0, 4'd5, 1'b0, 1'b0);
      step(4'b0011, 4'd2, 1'b0, 4'd6, 1'b1, 1'b0);
      step(4'b0001, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0);
      cnt_m = 4'd7;
    end else begin
      step(4'b0011, 4'd2, 1'b1, 4'd3, 1'b0, 1'b0);
      clear_err();
      step(4'b0001, 4'd1, 1'b1, 4'd3, 1'b0, 1'b0);
      clear_err();
    end

    // multi-bit jumps, sticky err, set beats clear
    step(4'b0111, 4'd5, 1'b1, cnt_m, 1'b0, 1'b0);
    clear_err();
    step(4'b0001, 4'd1, 1'b1, cnt_m, 1'b0, 1'b0);
    clear_err();
    step(4'b0111, 4'd5, 1'b1, cnt_m, 1'b0, 1'b1);
    check("err_set_wins", 16'(err), 16'(1));
    clear_err();

    // reach b=6, then reset mid-run
    cnt_m = sat_inc(cnt_m);
    step(4'b0101, 4'd6, 1'b0, cnt_m, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst", 16'({locked, upd, err, step_cnt, b_out, dir_obs}), 16'(0));
    @(negedge clk);
    rst = 1'b0;
    cnt_m = '0;
    @(negedge clk);
    check("relock_e1", 16'(locked), 16'(0));
    @(negedge clk);
    check("relock_e2", 16'(locked), 16'(0));
    @(negedge clk);
    check("relock_e3", 16'(locked), 16'(1));
    check("relock_b", 16'(b_out), 16'(6));
    check("relock_upd", 16'(upd), 16'(0));
    check("relock_err", 16'(err), 16'(0));
    @(negedge clk);
    check("relock_noupd", 16'(upd), 16'(0));

    // walk up to 15, then wrap to 0
    for (int i = 7; i < 16; i++) begin
      cnt_m = sat_inc(cnt_m);
      step(enc(i), W'(i), 1'b0, cnt_m, 1'b1, 1'b0);
    end
    cnt_m = sat_inc(cnt_m);
    step(4'b0000, 4'd0, 1'b0, cnt_m, 1'b1, 1'b0);
    check("wrap_cnt", 16'(step_cnt), 16'(10));

    // saturation
    for (int i = 1; i <= 20; i++) begin
      cnt_m = sat_inc(cnt_m);
      step(enc(i % 16), W'(i % 16), 1'b0, cnt_m, 1'b1, 1'b0);
    end
    check("sat_cnt", 16'(step_cnt), 16'(15));
    check("sat_err", 16'(err), 16'(0));
    check("sb_final", 16'(exp_q.size()), 16'(0));

    // report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
Receiving end for a Gray-coded count produced asynchronously by a producer counter. Synchronizes the Gray bus into the local clock, decodes it to binary, and registers the result. Checks that every observed change is a single legal Gray step, counts the legal steps, and flags protocol violations. Sits between an asynchronous Gray-coded pointer or position source and local binary consumers.

Parameters:
WIDTH, 4, Gray/binary bus width (>=2)
SYNC_STAGES, 2, synchronizer flop depth (>=2)
CNT_W, 16, width of legal-step counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
g_in  input  WIDTH  asynchronous Gray-coded count
err_clr  input  1  synchronous clear of sticky err
b_out  output  WIDTH  registered binary decode of synchronized g_in
upd  output  1  one-cycle pulse: b_out changed this cycle
locked  output  1  high once the first valid sample is loaded
err  output  1  sticky: illegal Gray transition seen
step_cnt  output  CNT_W  count of legal steps, saturating
dir  output  1  present only with GRAY_DEC_DIR_EN: 1 = last step up, 0 = down

Behaviour:
- Reset (async assert, sync release): sync flops, b_out, upd, locked, err, step_cnt and dir all 0; FSM enters INIT.
- Synchronizer: SYNC_STAGES flops in series on g_in; the last stage is g_s. No logic between the stages.
- Decode: b_new[WIDTH-1] = g_s[WIDTH-1]; b_new[i] = b_new[i+1] ^ g_s[i].
- FSM:
  - INIT: wait counter counts SYNC_STAGES edges after reset release, then LOAD.
  - LOAD: b_out <= b_new, locked <= 1, no upd, no check, then RUN.
  - RUN: compare g_s against the previous registered Gray value g_prev each cycle.
- RUN, no change: upd = 0, all state holds.
- RUN, change with Hamming(g_s, g_prev) == 1 and delta = b_new - b_out (mod 2^WIDTH) == 1 (up step):
  - b_out <= b_new, upd = 1.
  - step_cnt increments, holding at all-ones.
- RUN, all other changes (multi-bit jump, or down step without the macro):
  - b_out <= b_new, upd = 1, err <= 1.
  - step_cnt unchanged.
- Wrap: Gray 1000 -> 0000 (binary 15 -> 0, WIDTH=4) is a legal +1 step.
- Latency: g_in stable before edge k -> b_out and upd valid after edge k+SYNC_STAGES.
- Sticky err: err_clr clears err. If err_clr coincides with a new violation, the set wins and err stays 1.
- Reset mid-operation: all outputs drop to 0 immediately. locked returns only after the INIT and LOAD sequence, i.e. SYNC_STAGES+1 edges after release.
- g_prev tracks g_s every cycle in LOAD and RUN.

Optional Feature:
Macro: GRAY_DEC_DIR_EN.
- Defined:
  - A single-bit change with delta == all-ones (-1 mod 2^WIDTH) is a legal down step.
  - Legal down steps increment step_cnt (a magnitude count).
  - dir port exists and registers 1 on a legal up step, 0 on a legal down step; it holds otherwise and resets to 0.
- Not defined:
  - dir port is absent.
  - A down step counts as a violation: err set, step_cnt unchanged.

Test Plan:
1. Reset release with g_in=0000, then 0001, 0011, 0010, each held 5 cycles -> locked=1 after 3 edges; b_out 0,1,2,3; one upd pulse per change, each 3 edges after the change; step_cnt=3; err=0.
2. Walk g_in up to 1000 (b_out=15), then 0000 -> b_out=0, upd pulse, err=0, step_cnt increments across the wrap.
3. From g_in=0001 (b=1) jump to 0111 -> b_out=5, upd=1, err=1, step_cnt unchanged. Pulse err_clr -> err=0. Repeat the jump with err_clr high on the detection cycle -> err=1.
4. Step g_in 0011 -> 0001 (binary 2 -> 1):
   - Macro undefined: err=1, step_cnt unchanged.
   - Macro defined: err=0, dir=0, step_cnt+1; then 0001 -> 0011 gives dir=1.
5. Assert rst for 1 cycle while in RUN with b_out=6 -> all outputs 0 asynchronously. After release with g_in=0101, locked=1 and b_out=6 after 3 edges, with no upd pulse and no err on the load.
6. Step count saturation with CNT_W=4: 20 legal up steps -> step_cnt holds 15, err=0.
